phy_reset_seq: RTL and testbench
================================

PHY_RESET_SEQ -- requirements
Module: phy_reset_seq

Interface
REQ-001 The module SHALL have parameter NUM_CH, default 2: number of PHY reset channels, range 1..16.
REQ-002 The module SHALL have parameter HOLD_CYCLES, default 65535: reset assertion length in clk cycles, minimum 1.
REQ-003 The module SHALL have parameter STAGGER_CYCLES, default 256: spacing between successive channel releases, minimum 1.
REQ-004 The module SHALL have parameter SETTLE_CYCLES, default 1024: wait from release to ready, minimum 1.
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock; all logic is synchronous to its rising edge.
REQ-006 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The module SHALL have port i_locked, input, 1 bit: PLL/clock-wizard lock, already synchronised to clk.
REQ-008 The module SHALL have port i_soft_rst, input, NUM_CH bits: per-channel single-cycle reset request.
REQ-009 The module SHALL have port o_phy_resetn, output, NUM_CH bits: active-low PHY reset, one bit per channel.
REQ-010 The module SHALL have port o_ready, output, NUM_CH bits: channel k is out of reset and settled.
REQ-011 The module SHALL have port o_all_ready, output, 1 bit: AND of o_ready.

Function
REQ-012 The top state machine SHALL have the states WAIT_LOCK, HOLD, STAGGER, SETTLE and RUN.
REQ-013 WAIT_LOCK SHALL go to HOLD in the cycle after i_locked is sampled high, with the counter cleared.
REQ-014 In HOLD, all o_phy_resetn SHALL stay 0 for exactly HOLD_CYCLES cycles; the FSM SHALL then enter STAGGER.
REQ-015 On entry to STAGGER, o_phy_resetn[0] SHALL rise; each subsequent channel k SHALL rise exactly STAGGER_CYCLES cycles after channel k-1.
REQ-016 The FSM SHALL enter SETTLE in the same cycle that the last channel is released.
REQ-017 SETTLE SHALL last SETTLE_CYCLES cycles, then enter RUN; all o_ready bits and o_all_ready SHALL rise on RUN entry.
REQ-018 In RUN, an i_soft_rst[k] pulse SHALL drive o_phy_resetn[k] and o_ready[k] to 0 in the next cycle and hold them for HOLD_CYCLES cycles.
REQ-019 After that hold, o_phy_resetn[k] SHALL rise, and o_ready[k] SHALL rise SETTLE_CYCLES cycles later; other channels SHALL be unaffected.
REQ-020 An i_soft_rst[k] arriving during channel k's own hold or settle SHALL restart the hold from the beginning.
REQ-021 i_soft_rst SHALL be ignored in any state other than RUN.
REQ-022 Simultaneous i_soft_rst on several channels SHALL be serviced independently and in parallel, with no staggering.
REQ-023 o_all_ready SHALL be registered and fall in the same cycle as any o_ready bit falls.
REQ-024 Counter widths SHALL be $clog2 of the largest cycle parameter plus 1; counters SHALL saturate and never wrap.

Reset
REQ-025 While rst=1, the FSM SHALL be in WAIT_LOCK, o_phy_resetn SHALL be all 0, o_ready SHALL be all 0, o_all_ready SHALL be 0, and all counters SHALL be 0.
REQ-026 An rst asserted mid-sequence SHALL abort it immediately, and the next cycle SHALL show the reset values.

Configuration
REQ-027 With macro PHY_RESET_LOCK_LOSS_RESEQ_EN defined, i_locked=0 in HOLD, STAGGER, SETTLE or RUN SHALL next cycle drive all outputs to their reset values and return the FSM to WAIT_LOCK.
REQ-028 With that macro defined, lock loss SHALL win over a simultaneous i_soft_rst.
REQ-029 Without the macro, i_locked SHALL be examined only in WAIT_LOCK, and lock loss afterwards SHALL be ignored.

Structure
REQ-030 A shared package phy_reset_pkg SHALL hold the FSM state enum and the default cycle-count constants.
REQ-031 Per-channel hold/settle counting in RUN SHALL be a sub-module phy_reset_chan, instantiated NUM_CH times.

Verification (NUM_CH=3, HOLD=16, STAGGER=4, SETTLE=8; i_locked rises at cycle t)
REQ-032 Power-up: rst low with i_locked high at t -> resetn[0] rises at t+17, resetn[1] at t+21, resetn[2] at t+25, o_all_ready rises at t+33.
REQ-033 Soft reset: i_soft_rst=3'b010 in RUN at cycle s -> resetn[1]=0 from s+1 to s+16, rises at s+17, ready[1] rises at s+25, channels 0 and 2 stay high throughout.
REQ-034 Retrigger: a second i_soft_rst[1] at s+10 -> resetn[1] rises at s+27 instead of s+17.
REQ-035 Mid-sequence reset: rst pulsed during STAGGER after resetn[0]=1 -> all outputs 0 next cycle, and the full sequence replays.
REQ-036 Lock loss with macro: i_locked=0 in RUN -> all outputs 0 next cycle, and the sequence restarts when lock returns; without macro -> outputs unchanged.
REQ-037 Ignored request: i_soft_rst=3'b111 during HOLD -> no change to the sequence timing of REQ-032.

Source files
------------

// File: rtl/phy_reset_pkg.sv
// +-------------------------------------------------------------------------+
// | phy_reset_pkg : shared FSM state types and default cycle constants      |
// | Revision      : 1.0                                                      |
// +-------------------------------------------------------------------------+
`default_nettype none

package phy_reset_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_HOLD      = 3'd1,
    ST_STAGGER   = 3'd2,
    ST_SETTLE    = 3'd3,
    ST_RUN       = 3'd4
  } phy_state_e;

  typedef enum logic [1:0] {
    CH_IDLE   = 2'd0,
    CH_HOLD   = 2'd1,
    CH_SETTLE = 2'd2
  } chan_state_e;

  localparam int c_DEF_NUM_CH         = 2;
  localparam int c_DEF_HOLD_CYCLES    = 65535;
  localparam int c_DEF_STAGGER_CYCLES = 256;
  localparam int c_DEF_SETTLE_CYCLES  = 1024;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/phy_reset_chan.sv
// +-------------------------------------------------------------------------+
// | phy_reset_chan : per-channel reset output with soft-reset hold/settle   |
// | Revision       : 1.0                                                     |
// +-------------------------------------------------------------------------+
`default_nettype none

module phy_reset_chan
  import phy_reset_pkg::*;
#(
  parameter int HOLD_CYCLES   = c_DEF_HOLD_CYCLES,
  parameter int SETTLE_CYCLES = c_DEF_SETTLE_CYCLES,
  parameter int CW            = 17
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_soft,
  input  logic i_release,
  input  logic i_ready_set,
  output logic o_resetn,
  output logic o_ready,
  output logic o_ready_nxt
);

  localparam logic [CW-1:0] c_HOLD_LAST   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] c_SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] c_ONE         = CW'(1);

  chan_state_e   r_st,     w_st_nxt;
  logic [CW-1:0] r_cnt,    w_cnt_nxt;
  logic          r_resetn, w_resetn_nxt;
  logic          r_ready,  w_ready_nxt;

  always_comb begin
    w_st_nxt     = r_st;
    w_cnt_nxt    = (r_cnt == '1) ? r_cnt : r_cnt + c_ONE;
    w_resetn_nxt = r_resetn;
    w_ready_nxt  = r_ready;
    if (i_clr) begin
      w_st_nxt     = CH_IDLE;
      w_cnt_nxt    = '0;
      w_resetn_nxt = 1'b0;
      w_ready_nxt  = 1'b0;
    end else if (i_soft) begin
      // A request during an ongoing hold or settle restarts the hold.
      w_st_nxt     = CH_HOLD;
      w_cnt_nxt    = '0;
      w_resetn_nxt = 1'b0;
      w_ready_nxt  = 1'b0;
    end else begin
      if (i_release)   w_resetn_nxt = 1'b1;
      if (i_ready_set) w_ready_nxt  = 1'b1;
      case (r_st)
        CH_IDLE: w_cnt_nxt = '0;
        CH_HOLD: begin
          if (r_cnt == c_HOLD_LAST) begin
            w_resetn_nxt = 1'b1;
            w_st_nxt     = CH_SETTLE;
            w_cnt_nxt    = '0;
          end
        end
        CH_SETTLE: begin
          if (r_cnt == c_SETTLE_LAST) begin
            w_ready_nxt = 1'b1;
            w_st_nxt    = CH_IDLE;
            w_cnt_nxt   = '0;
          end
        end
        default: begin
          w_st_nxt  = CH_IDLE;
          w_cnt_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st     <= CH_IDLE;
      r_cnt    <= '0;
      r_resetn <= 1'b0;
      r_ready  <= 1'b0;
    end else begin
      r_st     <= w_st_nxt;
      r_cnt    <= w_cnt_nxt;
      r_resetn <= w_resetn_nxt;
      r_ready  <= w_ready_nxt;
    end
  end

  assign o_resetn    = r_resetn;
  assign o_ready     = r_ready;
  assign o_ready_nxt = rst ? 1'b0 : w_ready_nxt;

endmodule

`default_nettype wire

// File: rtl/phy_reset_seq.sv
// +-------------------------------------------------------------------------+
// | phy_reset_seq : lock-gated, staggered PHY reset release sequencer       |
// | Option        : PHY_RESET_LOCK_LOSS_RESEQ_EN re-sequences on lock loss  |
// | Revision      : 1.0                                                      |
// +-------------------------------------------------------------------------+
`default_nettype none

module phy_reset_seq
  import phy_reset_pkg::*;
#(
  parameter int NUM_CH         = c_DEF_NUM_CH,
  parameter int HOLD_CYCLES    = c_DEF_HOLD_CYCLES,
  parameter int STAGGER_CYCLES = c_DEF_STAGGER_CYCLES,
  parameter int SETTLE_CYCLES  = c_DEF_SETTLE_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_locked,
  input  logic [NUM_CH-1:0] i_soft_rst,
  output logic [NUM_CH-1:0] o_phy_resetn,
  output logic [NUM_CH-1:0] o_ready,
  output logic              o_all_ready
);

  localparam int CW  = $clog2(max3(HOLD_CYCLES, STAGGER_CYCLES, SETTLE_CYCLES)) + 1;
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [CW-1:0]  c_HOLD_LAST   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0]  c_STAG_LAST   = CW'(STAGGER_CYCLES - 1);
  localparam logic [CW-1:0]  c_SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0]  c_ONE         = CW'(1);
  localparam logic [CHW-1:0] c_CH_ONE      = CHW'(1);

  phy_state_e         r_state, w_state_nxt;
  logic [CW-1:0]      r_cnt,   w_cnt_nxt;
  logic [CHW-1:0]     r_ch,    w_ch_nxt;
  logic               w_lock_loss;
  logic [NUM_CH-1:0]  w_rel;
  logic [NUM_CH-1:0]  w_soft;
  logic               w_ready_set;
  logic [NUM_CH-1:0]  w_ready_nxt;
  logic               r_all_ready;

`ifdef PHY_RESET_LOCK_LOSS_RESEQ_EN
  assign w_lock_loss = (r_state != ST_WAIT_LOCK) && !i_locked;
`else
  assign w_lock_loss = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_WAIT_LOCK;
      r_cnt   <= '0;
      r_ch    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ch    <= w_ch_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = (r_cnt == '1) ? r_cnt : r_cnt + c_ONE;
    w_ch_nxt    = r_ch;
    case (r_state)
      ST_WAIT_LOCK: begin
        w_cnt_nxt = '0;
        if (i_locked) w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (r_cnt == c_HOLD_LAST) begin
          w_cnt_nxt   = '0;
          w_ch_nxt    = '0;
          // Single-channel builds release their only channel on HOLD exit.
          w_state_nxt = (NUM_CH == 1) ? ST_SETTLE : ST_STAGGER;
        end
      end
      ST_STAGGER: begin
        if (r_cnt == c_STAG_LAST) begin
          w_cnt_nxt = '0;
          w_ch_nxt  = r_ch + c_CH_ONE;
          if (int'(r_ch) + 1 >= NUM_CH - 1) w_state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (r_cnt == c_SETTLE_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN:  w_cnt_nxt = '0;
      default: begin
        w_state_nxt = ST_WAIT_LOCK;
        w_cnt_nxt   = '0;
        w_ch_nxt    = '0;
      end
    endcase
    if (w_lock_loss) begin
      w_state_nxt = ST_WAIT_LOCK;
      w_cnt_nxt   = '0;
      w_ch_nxt    = '0;
    end
  end

  always_comb begin
    w_rel       = '0;
    w_ready_set = 1'b0;
    w_soft      = '0;
    if (!w_lock_loss) begin
      if (r_state == ST_HOLD && r_cnt == c_HOLD_LAST) w_rel[0] = 1'b1;
      if (r_state == ST_STAGGER && r_cnt == c_STAG_LAST) begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (k == int'(r_ch) + 1) w_rel[k] = 1'b1;
        end
      end
      w_ready_set = (r_state == ST_SETTLE) && (r_cnt == c_SETTLE_LAST);
      w_soft      = i_soft_rst & {NUM_CH{r_state == ST_RUN}};
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
      phy_reset_chan #(
        .HOLD_CYCLES   (HOLD_CYCLES),
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .CW            (CW)
      ) u_chan (
        .clk         (clk),
        .rst         (rst),
        .i_clr       (w_lock_loss),
        .i_soft      (w_soft[gi]),
        .i_release   (w_rel[gi]),
        .i_ready_set (w_ready_set),
        .o_resetn    (o_phy_resetn[gi]),
        .o_ready     (o_ready[gi]),
        .o_ready_nxt (w_ready_nxt[gi])
      );
    end
  endgenerate

  // Built from next-cycle ready bits so it falls together with any o_ready.
  always_ff @(posedge clk) begin
    if (rst) r_all_ready <= 1'b0;
    else     r_all_ready <= &w_ready_nxt;
  end

  assign o_all_ready = r_all_ready;

endmodule

`default_nettype wire

// File: tb/tb_phy_reset_seq.sv
// +-------------------------------------------------------------------------+
// | tb_phy_reset_seq : randomized bench with a timestamp reference model    |
// | Revision         : 1.0                                                   |
// +-------------------------------------------------------------------------+
`default_nettype none

module tb_phy_reset_seq;

  localparam int N  = 3;
  localparam int H  = 16;
  localparam int ST = 4;
  localparam int SE = 8;
  localparam int NCYC = 4000;

`ifdef PHY_RESET_LOCK_LOSS_RESEQ_EN
  localparam bit LL_EN = 1'b1;
`else
  localparam bit LL_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         i_locked;
  logic [N-1:0] i_soft_rst;
  logic [N-1:0] o_phy_resetn;
  logic [N-1:0] o_ready;
  logic         o_all_ready;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Model: sequence start cycle t plus the latest accepted soft request per channel.
  bit           started;
  int           t;
  bit           soft_act [N];
  int           s_last   [N];
  logic [N-1:0] e_rn;
  logic [N-1:0] e_rdy;
  int           t_run;

  phy_reset_seq #(
    .NUM_CH         (N),
    .HOLD_CYCLES    (H),
    .STAGGER_CYCLES (ST),
    .SETTLE_CYCLES  (SE)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .i_locked     (i_locked),
    .i_soft_rst   (i_soft_rst),
    .o_phy_resetn (o_phy_resetn),
    .o_ready      (o_ready),
    .o_all_ready  (o_all_ready)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, act, exp);
    end
  endtask

  task automatic clear_soft();
    for (int k = 0; k < N; k++) begin
      soft_act[k] = 1'b0;
      s_last[k]   = 0;
    end
  endtask

  initial begin
    rst        = 1'b1;
    i_locked   = 1'b0;
    i_soft_rst = '0;
    started    = 1'b0;
    t          = 0;
    clear_soft();

    for (int i = 0; i < NCYC; i++) begin
      @(posedge clk);
      cyc++;
      #1;
      // Inputs for this cycle; they take effect at the next rising edge.
      rst = (i < 4) || ($urandom_range(0, 399) == 0);
      if (i < 6)
        i_locked = 1'b0;
      else if (i_locked)
        i_locked = ($urandom_range(0, 299) != 0);
      else
        i_locked = ($urandom_range(0, 5) == 0);
      i_soft_rst = ($urandom_range(0, 9) == 0) ? N'($urandom_range(1, 7)) : '0;

      @(negedge clk);
      e_rn  = '0;
      e_rdy = '0;
      t_run = t + H + 1 + (N - 1) * ST + SE;
      if (started && cyc > t) begin
        for (int k = 0; k < N; k++) begin
          if (soft_act[k]) begin
            e_rn[k]  = (cyc >= s_last[k] + H + 1);
            e_rdy[k] = (cyc >= s_last[k] + H + 1 + SE);
          end else begin
            e_rn[k]  = (cyc >= t + H + 1 + k * ST);
            e_rdy[k] = (cyc >= t_run);
          end
        end
      end
      check_eq("resetn",    32'(o_phy_resetn), 32'(e_rn));
      check_eq("ready",     32'(o_ready),      32'(e_rdy));
      check_eq("all_ready", 32'(o_all_ready),  32'(&e_rdy));

      if (rst) begin
        started = 1'b0;
        clear_soft();
      end else if (!started) begin
        if (i_locked) begin
          started = 1'b1;
          t       = cyc;
          clear_soft();
        end
      end else if (LL_EN && !i_locked && cyc >= t + 1) begin
        started = 1'b0;
        clear_soft();
      end else if (cyc >= t_run) begin
        for (int k = 0; k < N; k++) begin
          if (i_soft_rst[k]) begin
            soft_act[k] = 1'b1;
            s_last[k]   = cyc;
          end
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
